// File: rtl/mips_cpu_mem_pkg.sv
// rtl/mips_cpu_mem_pkg.sv - shared types for the MIPS CPU Avalon master bridge
package mips_cpu_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_ERR  = 2'b10
  } state_e;

  // The reserved size has no legal alignment, so it always takes the error path.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      SZ_WORD: is_misaligned = |off;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_mem_lane.sv
// rtl/mips_cpu_mem_lane.sv - little-endian lane steering for stores and loads
module mips_cpu_mem_lane
  import mips_cpu_mem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] readdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  assign shifted = readdata >> {off, 3'b000};

  always_comb begin
    byteenable = 4'b0000;
    writedata  = wdata;
    load_data  = readdata;
    case (size)
      SZ_BYTE: begin
        byteenable = 4'b0001 << off;
        writedata  = {4{wdata[7:0]}};
        load_data  = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        byteenable = off[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{wdata[15:0]}};
        load_data  = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        byteenable = 4'b1111;
      end
      default: begin
        byteenable = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_avalon_master.sv
// rtl/mips_cpu_avalon_master.sv - single-transfer Avalon-MM master for the MIPS datapath
module mips_cpu_avalon_master
  import mips_cpu_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic [1:0]  err,
  output logic [31:0] rdata,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_e          state, state_next;
  size_e           size_q;
  logic            signed_q;
  logic [1:0]      off_q;
  logic [CW-1:0]   stall_cnt;
  logic            accept, misalign, stall_last;
  size_e           lane_size;
  logic [1:0]      lane_off;
  logic            lane_sign;
  logic [3:0]      lane_be;
  logic [31:0]     lane_wdata, lane_rdata;

  assign req_ready  = (state == ST_IDLE);
  assign accept     = req && req_ready;
  assign misalign   = is_misaligned(size_e'(req_size), req_addr[1:0]);
  assign stall_last = (stall_cnt == CW'(TIMEOUT_CYCLES - 1));

  // One lane instance: fed from the request while idle (store setup), from latched fields during BUS (load return).
  assign lane_size = req_ready ? size_e'(req_size) : size_q;
  assign lane_off  = req_ready ? req_addr[1:0] : off_q;
  assign lane_sign = req_ready ? req_signed : signed_q;

  mips_cpu_mem_lane u_lane (
    .size       (lane_size),
    .off        (lane_off),
    .sign_ext   (lane_sign),
    .wdata      (req_wdata),
    .readdata   (readdata),
    .byteenable (lane_be),
    .writedata  (lane_wdata),
    .load_data  (lane_rdata)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = misalign ? ST_ERR : ST_BUS;
      ST_BUS:  if (!waitrequest || stall_last) state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      size_q     <= SZ_BYTE;
      signed_q   <= 1'b0;
      off_q      <= 2'b00;
      stall_cnt  <= '0;
      done       <= 1'b0;
      err        <= ERR_OK;
      rdata      <= '0;
      address    <= '0;
      byteenable <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            size_q    <= size_e'(req_size);
            signed_q  <= req_signed;
            off_q     <= req_addr[1:0];
            stall_cnt <= '0;
            if (!misalign) begin
              address    <= {req_addr[31:2], 2'b00};
              byteenable <= lane_be;
              writedata  <= lane_wdata;
              read       <= !req_write;
              write      <= req_write;
            end
          end
        end
        ST_BUS: begin
          if (!waitrequest) begin
            read  <= 1'b0;
            write <= 1'b0;
            done  <= 1'b1;
            err   <= ERR_OK;
            if (read) rdata <= lane_rdata;
          end else if (stall_last) begin
            read  <= 1'b0;
            write <= 1'b0;
            done  <= 1'b1;
            err   <= ERR_TIMEOUT;
          end else begin
            stall_cnt <= stall_cnt + CW'(1);
          end
        end
        ST_ERR: begin
          done <= 1'b1;
          err  <= ERR_MISALIGN;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_avalon_master.sv
// tb/tb_mips_cpu_avalon_master.sv - directed self-checking bench for mips_cpu_avalon_master
module tb_mips_cpu_avalon_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        done;
  logic [1:0]  err;
  logic [31:0] rdata;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata = '0;

  always #5 clk = ~clk;

  mips_cpu_avalon_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .address    (address),
    .byteenable (byteenable),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .waitrequest(waitrequest),
    .readdata   (readdata)
  );

  // Slave model: stall the first stalls_req edges of each command, or forever when stuck.
  int   stalls_req = 0;
  int   stall_seen = 0;
  logic stuck = 1'b0;
  assign waitrequest = stuck || (stall_seen < stalls_req);
  always @(posedge clk) begin
    if (!(read || write)) stall_seen <= 0;
    else if (waitrequest) stall_seen <= stall_seen + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int          r_cmd, r_lat, r_dones, r_both;
  logic        r_rd, r_wr, r_extra;
  logic [3:0]  r_be;
  logic [31:0] r_wd, r_addr, r_rdata;
  logic [1:0]  r_err;

  task automatic xfer(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd, input int st);
    stalls_req = st;
    @(posedge clk); #1;
    req = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req = 1'b0; req_addr = '0; req_wdata = '0; req_size = 2'b00; req_signed = 1'b0;
    r_cmd = 0; r_lat = 0; r_dones = 0; r_both = 0; r_rd = 0; r_wr = 0;
    r_be = '0; r_wd = '0; r_addr = '0; r_rdata = '0; r_err = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (read || write) begin
        r_cmd++;
        r_rd = r_rd | read;
        r_wr = r_wr | write;
        r_be = byteenable;
        r_wd = writedata;
        r_addr = address;
        if (read && write) r_both++;
      end
      if (done) begin
        r_dones = 1;
        r_lat = i;
        r_err = err;
        r_rdata = rdata;
        break;
      end
    end
    check("done_seen", r_dones, 1);
    check("rd_wr_together", r_both, 0);
    @(negedge clk);
    r_extra = done;
    check("single_done", {31'b0, r_extra}, 0);
  endtask

  initial begin
    #1;
    check("rst_ready", {31'b0, req_ready}, 1);
    check("rst_cmd", {30'b0, read, write}, 0);
    check("rst_done_err", {29'b0, done, err}, 0);
    check("rst_addr", address, 0);
    check("rst_rdata", rdata, 0);
    @(negedge clk); rst_n = 1'b1;

    // LW zero-wait
    readdata = 32'h8899AABB;
    xfer(1'b0, 2'b10, 1'b0, 32'hBFC00010, 32'h0, 0);
    check("lw_cmd_cycles", r_cmd, 1);
    check("lw_rw", {30'b0, r_rd, r_wr}, 32'h2);
    check("lw_be", {28'b0, r_be}, 32'hF);
    check("lw_addr", r_addr, 32'hBFC00010);
    check("lw_lat", r_lat, 2);
    check("lw_err", {30'b0, r_err}, 0);
    check("lw_rdata", r_rdata, 32'h8899AABB);

    // LB signed / LBU top lane
    readdata = 32'h80112233;
    xfer(1'b0, 2'b00, 1'b1, 32'hBFC00013, 32'h0, 0);
    check("lb_be", {28'b0, r_be}, 32'h8);
    check("lb_addr", r_addr, 32'hBFC00010);
    check("lb_rdata", r_rdata, 32'hFFFFFF80);
    xfer(1'b0, 2'b00, 1'b0, 32'hBFC00013, 32'h0, 0);
    check("lbu_rdata", r_rdata, 32'h00000080);

    // LH signed upper half
    readdata = 32'h80017F00;
    xfer(1'b0, 2'b01, 1'b1, 32'h00001002, 32'h0, 0);
    check("lh_be", {28'b0, r_be}, 32'hC);
    check("lh_rdata", r_rdata, 32'hFFFF8001);

    // SH with 3 stalls
    xfer(1'b1, 2'b01, 1'b0, 32'h10000002, 32'h0000BEEF, 3);
    check("sh_cmd_cycles", r_cmd, 4);
    check("sh_rw", {30'b0, r_rd, r_wr}, 32'h1);
    check("sh_wd", r_wd, 32'hBEEFBEEF);
    check("sh_be", {28'b0, r_be}, 32'hC);
    check("sh_err", {30'b0, r_err}, 0);
    check("sh_lat", r_lat, 5);
    check("sh_rdata_hold", r_rdata, 32'hFFFF8001);

    // SB offset 1
    xfer(1'b1, 2'b00, 1'b0, 32'h20000001, 32'h12345678, 0);
    check("sb_be", {28'b0, r_be}, 32'h2);
    check("sb_wd", r_wd, 32'h78787878);

    // Misaligned LW and reserved size
    xfer(1'b0, 2'b10, 1'b0, 32'h10000001, 32'h0, 0);
    check("mis_cmd", r_cmd, 0);
    check("mis_err", {30'b0, r_err}, 1);
    check("mis_lat", r_lat, 2);
    xfer(1'b1, 2'b11, 1'b0, 32'h10000000, 32'h0, 0);
    check("rsvd_cmd", r_cmd, 0);
    check("rsvd_err", {30'b0, r_err}, 1);

    // Timeout with waitrequest stuck
    stuck = 1'b1;
    xfer(1'b0, 2'b10, 1'b0, 32'h30000000, 32'h0, 0);
    check("to_cmd_cycles", r_cmd, 4);
    check("to_err", {30'b0, r_err}, 2);
    check("to_lat", r_lat, 5);

    // Async reset mid-BUS
    @(posedge clk); #1;
    req = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h40000000;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("rst_mid_read_before", {31'b0, read}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_read", {31'b0, read}, 0);
    check("rst_mid_ready", {31'b0, req_ready}, 1);
    check("rst_mid_addr", address, 0);
    stuck = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Back-to-back: new request raised during the done cycle
    readdata = 32'h11223344;
    stalls_req = 0;
    @(posedge clk); #1;
    req = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h50000000;
    @(posedge clk); #1;
    req = 1'b0;
    r_dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin r_dones = 1; break; end
    end
    check("b2b_first_done", r_dones, 1);
    check("b2b_first_rdata", rdata, 32'h11223344);
    check("b2b_ready_on_done", {31'b0, req_ready}, 1);
    req = 1'b1; req_addr = 32'h50000004;
    readdata = 32'h55667788;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("b2b_read", {31'b0, read}, 1);
    check("b2b_addr", address, 32'h50000004);
    @(negedge clk);
    check("b2b_second_done", {31'b0, done}, 1);
    check("b2b_second_rdata", rdata, 32'h55667788);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
